// File: rtl/game_pkg.sv
// Shared encodings and widths for the game session controller and its helpers.
package game_pkg;

    localparam int LIVES_W = 4;
    localparam int CNT_W   = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_COUNT = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;
    localparam logic [2:0] ST_WIN   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_COUNT = ST_COUNT,
        S_PLAY  = ST_PLAY,
        S_PAUSE = ST_PAUSE,
        S_OVER  = ST_OVER,
        S_WIN   = ST_WIN
    } state_t;

endpackage

// File: rtl/game_session_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sat is high while the count is all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             sat
);

    assign sat = &count;

    // Count register: clear has priority, increments stop at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + WIDTH'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/game_session_ctrl.sv
// Game session controller: song select, beat countdown, play gating, pause,
// lives/combo bookkeeping and win/game-over decision.
module game_session_ctrl #(
    parameter int NUM_SONGS = 4,
    parameter int SONG_W    = 2,
    parameter int LIVES     = 3,
    parameter int COUNTDOWN = 4,
    parameter int COMBO_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 beat_tick,
    input  logic                 btn_start,
    input  logic                 btn_pause,
    input  logic [NUM_SONGS-1:0] sel_pulse,
    input  logic                 hit,
    input  logic                 miss,
    input  logic                 song_done,
    output logic [SONG_W-1:0]    song,
    output logic                 play_en,
    output logic                 gen_clr,
    output logic [2:0]           state,
    output logic [3:0]           lives,
    output logic [3:0]           cnt_left,
    output logic [COMBO_W-1:0]   combo,
    output logic [COMBO_W-1:0]   best_combo,
    output logic [NUM_SONGS-1:0] led
);
    import game_pkg::*;

    function automatic logic [SONG_W-1:0] lowest_idx(input logic [NUM_SONGS-1:0] v);
        logic [SONG_W-1:0] idx;
        idx = '0;
        for (int i = NUM_SONGS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = SONG_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    state_t               cur;
    state_t               nxt;
    logic [SONG_W-1:0]    song_nxt;
    logic [LIVES_W-1:0]   lives_nxt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [COMBO_W-1:0]   best_nxt;
    logic [COMBO_W-1:0]   combo_up;
    logic                 gen_clr_nxt;
    logic                 combo_inc;
    logic                 combo_clr;
    logic                 combo_sat;

    assign state    = cur;
    assign combo_up = combo_sat ? combo : combo + COMBO_W'(1);

    sat_counter #(.WIDTH(COMBO_W)) u_combo (
        .clk   (clk),
        .rst   (rst),
        .inc   (combo_inc),
        .clr   (combo_clr),
        .count (combo),
        .sat   (combo_sat)
    );

    // Next-state and next-value decode for every session register.
    always_comb begin
        nxt         = cur;
        song_nxt    = song;
        lives_nxt   = lives;
        cnt_nxt     = cnt_left;
        best_nxt    = best_combo;
        gen_clr_nxt = 1'b0;
        combo_inc   = 1'b0;
        combo_clr   = 1'b0;
        case (cur)
            S_IDLE, S_OVER, S_WIN: begin
                if (|sel_pulse) begin
                    song_nxt = lowest_idx(sel_pulse);
                end else begin
                    song_nxt = song;
                end
                if (btn_start) begin
                    nxt         = S_COUNT;
                    lives_nxt   = LIVES_W'(LIVES);
                    cnt_nxt     = CNT_W'(COUNTDOWN);
                    best_nxt    = '0;
                    combo_clr   = 1'b1;
                    gen_clr_nxt = 1'b1;
                end else begin
                    nxt = cur;
                end
            end
            S_COUNT: begin
                if (btn_start) begin
                    cnt_nxt     = CNT_W'(COUNTDOWN);
                    gen_clr_nxt = 1'b1;
                end else if (beat_tick && (cnt_left != 4'd0)) begin
                    cnt_nxt = cnt_left - 4'd1;
                    nxt     = (cnt_left == 4'd1) ? S_PLAY : S_COUNT;
                end else begin
                    nxt = cur;
                end
            end
            S_PLAY: begin
                // A miss overrides a simultaneous hit.
                if (miss) begin
                    combo_clr = 1'b1;
                    lives_nxt = (lives != 4'd0) ? lives - 4'd1 : 4'd0;
                end else if (hit) begin
                    combo_inc = 1'b1;
                    best_nxt  = (combo_up > best_combo) ? combo_up : best_combo;
                end else begin
                    best_nxt = best_combo;
                end
                // Game over outranks win, which outranks pause.
                if (miss && (lives <= 4'd1)) begin
                    nxt = S_OVER;
                end else if (song_done) begin
                    nxt = S_WIN;
                end else if (btn_pause) begin
                    nxt = S_PAUSE;
                end else begin
                    nxt = cur;
                end
            end
            S_PAUSE: begin
                if (btn_start) begin
                    nxt       = S_IDLE;
                    combo_clr = 1'b1;
                end else if (btn_pause) begin
                    nxt = S_PLAY;
                end else begin
                    nxt = cur;
                end
            end
            default: begin
                nxt = S_IDLE;
            end
        endcase
    end

    // Session registers; every output is taken straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur        <= S_IDLE;
            song       <= '0;
            led        <= NUM_SONGS'(1);
            play_en    <= 1'b0;
            gen_clr    <= 1'b0;
            lives      <= LIVES_W'(LIVES);
            cnt_left   <= '0;
            best_combo <= '0;
        end else begin
            cur        <= nxt;
            song       <= song_nxt;
            led        <= NUM_SONGS'(1) << song_nxt;
            play_en    <= (nxt == S_PLAY);
            gen_clr    <= gen_clr_nxt;
            lives      <= lives_nxt;
            cnt_left   <= cnt_nxt;
            best_combo <= best_nxt;
        end
    end

endmodule

// File: tb/tb_game_session_ctrl.sv
// Directed scenarios plus randomized stimulus checked against a behavioural session model.
module tb_game_session_ctrl;

    localparam int NS = 4;
    localparam int SW = 2;
    localparam int LV = 3;
    localparam int CD = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          beat_tick = 1'b0;
    logic          btn_start = 1'b0;
    logic          btn_pause = 1'b0;
    logic [NS-1:0] sel_pulse = '0;
    logic          hit = 1'b0;
    logic          miss = 1'b0;
    logic          song_done = 1'b0;
    logic [SW-1:0] song;
    logic          play_en;
    logic          gen_clr;
    logic [2:0]    state;
    logic [3:0]    lives;
    logic [3:0]    cnt_left;
    logic [CW-1:0] combo;
    logic [CW-1:0] best_combo;
    logic [NS-1:0] led;

    always #5 clk = ~clk;

    game_session_ctrl #(
        .NUM_SONGS(NS), .SONG_W(SW), .LIVES(LV), .COUNTDOWN(CD), .COMBO_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .beat_tick(beat_tick), .btn_start(btn_start),
        .btn_pause(btn_pause), .sel_pulse(sel_pulse), .hit(hit), .miss(miss),
        .song_done(song_done), .song(song), .play_en(play_en), .gen_clr(gen_clr),
        .state(state), .lives(lives), .cnt_left(cnt_left), .combo(combo),
        .best_combo(best_combo), .led(led)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference session: 0 idle, 1 countdown, 2 play, 3 pause, 4 over, 5 win.
    int m_state = 0, m_song = 0, m_lives = LV, m_cnt = 0, m_combo = 0, m_best = 0, m_gen = 0;

    task automatic model_update();
        int ns;
        if (rst) begin
            m_state = 0; m_song = 0; m_lives = LV; m_cnt = 0;
            m_combo = 0; m_best = 0; m_gen = 0;
            return;
        end
        m_gen = 0;
        ns = m_state;
        if (m_state == 0 || m_state == 4 || m_state == 5) begin
            for (int i = NS - 1; i >= 0; i--) if (sel_pulse[i]) m_song = i;
            if (btn_start) begin
                ns = 1; m_lives = LV; m_cnt = CD; m_combo = 0; m_best = 0; m_gen = 1;
            end
        end else if (m_state == 1) begin
            if (btn_start) begin
                m_cnt = CD; m_gen = 1;
            end else if (beat_tick) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) ns = 2;
            end
        end else if (m_state == 2) begin
            if (miss) begin
                m_combo = 0;
                m_lives = m_lives - 1;
            end else if (hit) begin
                if (m_combo < (1 << CW) - 1) m_combo = m_combo + 1;
                if (m_combo > m_best) m_best = m_combo;
            end
            if (miss && m_lives == 0) ns = 4;
            else if (song_done) ns = 5;
            else if (btn_pause) ns = 3;
        end else if (m_state == 3) begin
            if (btn_start) begin
                ns = 0; m_combo = 0;
            end else if (btn_pause) begin
                ns = 2;
            end
        end
        m_state = ns;
    endtask

    task automatic compare_all();
        check_eq("state", 32'(state), m_state);
        check_eq("song", 32'(song), m_song);
        check_eq("led", 32'(led), 1 << m_song);
        check_eq("play_en", 32'(play_en), (m_state == 2) ? 1 : 0);
        check_eq("gen_clr", 32'(gen_clr), m_gen);
        check_eq("lives", 32'(lives), m_lives);
        check_eq("cnt_left", 32'(cnt_left), m_cnt);
        check_eq("combo", 32'(combo), m_combo);
        check_eq("best_combo", 32'(best_combo), m_best);
    endtask

    task automatic apply(input logic r, input logic tk, input logic st, input logic pa,
                         input logic [NS-1:0] sel, input logic h, input logic m, input logic d);
        rst = r; beat_tick = tk; btn_start = st; btn_pause = pa;
        sel_pulse = sel; hit = h; miss = m; song_done = d;
        model_update();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0; beat_tick = 1'b0; btn_start = 1'b0; btn_pause = 1'b0;
        sel_pulse = '0; hit = 1'b0; miss = 1'b0; song_done = 1'b0;
    endtask

    task automatic count_in();
        for (int i = 0; i < CD; i++) begin
            apply(0, 1, 0, 0, '0, 0, 0, 0);
            check_eq("cd_cnt", 32'(cnt_left), CD - 1 - i);
        end
        check_eq("cd_state_play", 32'(state), 2);
        check_eq("cd_play_en", 32'(play_en), 1);
    endtask

    initial begin
        apply(1, 0, 0, 0, '0, 0, 0, 0);
        apply(1, 0, 0, 0, '0, 0, 0, 0);
        check_eq("rst_state", 32'(state), 0);
        check_eq("rst_led", 32'(led), 1);
        check_eq("rst_lives", 32'(lives), 3);

        apply(0, 0, 0, 0, 4'b0100, 0, 0, 0);
        check_eq("sel_song", 32'(song), 2);
        check_eq("sel_led", 32'(led), 4'b0100);
        check_eq("sel_state", 32'(state), 0);

        apply(0, 0, 1, 0, '0, 0, 0, 0);
        check_eq("start_state", 32'(state), 1);
        check_eq("start_gen_clr", 32'(gen_clr), 1);
        check_eq("start_cnt", 32'(cnt_left), 4);
        apply(0, 0, 0, 0, '0, 0, 0, 0);
        check_eq("gen_clr_one_cycle", 32'(gen_clr), 0);
        count_in();

        for (int i = 0; i < 5; i++) apply(0, 0, 0, 0, '0, 1, 0, 0);
        apply(0, 0, 0, 0, '0, 0, 1, 0);
        apply(0, 0, 0, 0, '0, 1, 0, 0);
        apply(0, 0, 0, 0, '0, 1, 0, 0);
        check_eq("play_combo", 32'(combo), 2);
        check_eq("play_best", 32'(best_combo), 5);
        check_eq("play_lives", 32'(lives), 2);

        apply(0, 0, 0, 0, '0, 0, 1, 0);
        check_eq("one_life", 32'(lives), 1);
        apply(0, 0, 0, 0, '0, 1, 1, 1);
        check_eq("over_state", 32'(state), 4);
        check_eq("over_lives", 32'(lives), 0);
        check_eq("over_combo", 32'(combo), 0);

        apply(0, 0, 1, 0, '0, 0, 0, 0);
        count_in();
        apply(0, 0, 0, 0, '0, 1, 0, 0);
        apply(0, 0, 0, 0, '0, 1, 0, 0);
        apply(0, 0, 0, 1, '0, 0, 0, 0);
        check_eq("pause_state", 32'(state), 3);
        check_eq("pause_play_en", 32'(play_en), 0);
        apply(0, 0, 0, 0, '0, 1, 0, 0);
        apply(0, 0, 0, 0, '0, 0, 1, 0);
        apply(0, 1, 0, 0, '0, 0, 0, 1);
        check_eq("pause_combo", 32'(combo), 2);
        check_eq("pause_lives", 32'(lives), 3);
        check_eq("pause_hold", 32'(state), 3);
        apply(0, 0, 0, 1, '0, 0, 0, 0);
        check_eq("resume_state", 32'(state), 2);
        check_eq("resume_play_en", 32'(play_en), 1);

        apply(0, 0, 0, 0, 4'b0001, 0, 0, 0);
        check_eq("sel_in_play", 32'(song), 2);
        apply(0, 0, 0, 0, '0, 0, 0, 1);
        check_eq("win_state", 32'(state), 5);
        apply(0, 0, 1, 0, 4'b0011, 0, 0, 0);
        check_eq("win_sel_song", 32'(song), 0);
        check_eq("win_restart", 32'(state), 1);
        check_eq("win_gen_clr", 32'(gen_clr), 1);

        for (int c = 0; c < 4000; c++) begin
            logic [NS-1:0] sel_v;
            sel_v = ($urandom_range(99, 0) < 8) ? NS'($urandom_range((1 << NS) - 1, 1)) : '0;
            apply($urandom_range(299, 0) == 0,
                  $urandom_range(99, 0) < 30,
                  $urandom_range(99, 0) < 3,
                  $urandom_range(99, 0) < 5,
                  sel_v,
                  $urandom_range(99, 0) < 40,
                  $urandom_range(99, 0) < 8,
                  $urandom_range(99, 0) < 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_session_ctrl.md
Name: game_session_ctrl

Overview:
- Parametrised session controller for the rhythm/maze game. It replaces the ad-hoc start/song-select latch logic at top level with a clocked state machine.
- Selects one of NUM_SONGS tracks, runs a beat countdown, and gates play. It supports pause/resume, tracks lives and combo from hit/miss strobes, and declares win or game over.
- Sits between the debounced/one-pulsed buttons and the note generator, audio, LCD and points blocks.

Parameters:
NUM_SONGS, 4, number of selectable songs (2..16)
SONG_W, 2, width of song index; must be >= clog2(NUM_SONGS)
LIVES, 3, lives loaded at start of each game (1..15)
COUNTDOWN, 4, beat ticks spent in COUNT before play begins (1..15)
COMBO_W, 8, combo counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
beat_tick  in  1  one-cycle strobe per beat, from the note generator beat clock after the one-pulse stage
btn_start  in  1  one-cycle pulse; start, or restart after game end
btn_pause  in  1  one-cycle pulse; toggles pause
sel_pulse  in  NUM_SONGS  one-cycle pulses, one bit per song
hit  in  1  one-cycle pulse, note hit
miss  in  1  one-cycle pulse, note missed
song_done  in  1  one-cycle pulse, track finished
song  out  SONG_W  selected song index
play_en  out  1  high only in PLAY; gates note generator, buzzer and keypad
gen_clr  out  1  one-cycle pulse clearing note generator and points on entry to COUNT
state  out  3  IDLE=0, COUNT=1, PLAY=2, PAUSE=3, OVER=4, WIN=5
lives  out  4  remaining lives
cnt_left  out  4  countdown beats remaining, for the 7-seg display
combo  out  COMBO_W  current consecutive hits, saturating
best_combo  out  COMBO_W  max combo this game
led  out  NUM_SONGS  one-hot, lit for the selected song

Behaviour:
- Reset values (rst=1 at a clk edge):
  - state=IDLE, song=0, led=1, play_en=0, gen_clr=0
  - lives=LIVES, cnt_left=0, combo=0, best_combo=0
- Song select:
  - Accepted only in IDLE, OVER and WIN.
  - On a sel_pulse bit set, song becomes the lowest set index, registered with 1-cycle latency. led becomes one-hot of song.
  - Pulses for indices >= NUM_SONGS are impossible by width. Selects in COUNT, PLAY or PAUSE are ignored.
- IDLE/OVER/WIN, on btn_start:
  - Go to COUNT, lives=LIVES, cnt_left=COUNTDOWN, combo=0, best_combo=0.
  - gen_clr=1 for exactly the first cycle in COUNT.
  - If btn_start and a sel_pulse arrive in the same cycle, the new song is taken first and the game starts with it.
- COUNT:
  - Each beat_tick decrements cnt_left.
  - The tick that makes cnt_left 0 moves the FSM to PLAY on the next edge.
  - btn_pause is ignored. btn_start restarts COUNT with cnt_left reloaded and gen_clr pulsed again.
- PLAY:
  - play_en=1.
  - hit: combo+1, saturating at all-ones. best_combo=max(best_combo, new combo), updated the same cycle.
  - miss: combo=0, lives-1. If lives was 1, go to OVER (lives=0).
  - hit and miss in the same cycle: miss wins, hit is ignored.
  - song_done with lives>0 goes to WIN. If miss-to-0 and song_done coincide, OVER wins.
  - btn_pause goes to PAUSE. btn_start is ignored.
- PAUSE:
  - play_en=0. hit, miss, song_done and beat_tick are ignored.
  - btn_pause returns to PLAY.
  - btn_start aborts to IDLE, with combo cleared and lives held.
- OVER/WIN:
  - play_en=0. lives, combo and best_combo are held for display.
- Output timing:
  - All outputs are registered; state changes are visible the cycle after the triggering pulse.
  - play_en is decoded from the registered state, so it rises the cycle state==PLAY.
- A reset during any state returns to the reset values on the same edge, with no gen_clr pulse.

Decomposition:
- Shared package game_pkg holds:
  - state encodings ST_IDLE..ST_WIN as 3-bit localparams
  - LIVES_W=4
  - CNT_W=4
- One sub-module is natural: sat_counter (param WIDTH; inc, clr, sat flag), used for combo.
- The lowest-set-bit song encoder stays inline as a function.

Test Plan:
- Reset, then sel_pulse=4'b0100 in IDLE -> next cycle song=2, led=4'b0100, state=IDLE.
- btn_start, then 4 beat_ticks -> gen_clr high exactly 1 cycle, cnt_left 4,3,2,1,0, state=PLAY after the 4th tick, play_en=1.
- PLAY: 5 hits, miss, 2 hits -> combo=2, best_combo=5, lives=2.
- PLAY with lives=1: hit+miss same cycle, together with song_done -> state=OVER, lives=0, combo=0.
- PLAY: btn_pause, then hit/miss pulses, then btn_pause -> counters unchanged while in PAUSE, play_en low, returns to PLAY.
- sel_pulse during PLAY is ignored; song_done -> WIN; then sel_pulse=4'b0011 together with btn_start -> song=0 and COUNT with gen_clr.
